magnetron_power_ctrl: RTL and testbench



---
 rtl/magnetron_power_ctrl.sv | 143 ++++++++++++++
 tb/tb_magnetron_power_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/magnetron_power_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : magnetron_power_ctrl
//  Brief    : Cook-state machine (IDLE/COOKING/PAUSED/DONE) with door
//             interlock, pause/resume and power-level duty-cycle modulation
//             of the magnetron enable over a fixed period.
//  Revision : 1.0 - initial release
// ============================================================================
module magnetron_power_ctrl #(
  parameter int MAX_LEVEL   = 10,
  parameter int SLOT_CYCLES = 4,
  parameter int LEVEL_W     = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic               timer_done,
  input  logic [LEVEL_W-1:0] power_level,
  output logic               mag_on,
  output logic               cooking,
  output logic               paused,
  output logic               done,
  output logic [LEVEL_W-1:0] level_active
);

  // One modulation period spans every level slot; cnt counts through it.
  localparam int PERIOD = MAX_LEVEL * SLOT_CYCLES;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // One extra bit so level*SLOT_CYCLES at full power never overflows.
  localparam int LIM_W  = CNT_W + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COOKING = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [LEVEL_W-1:0] lvl_nxt;
  logic [LEVEL_W-1:0] lvl_c;
  logic [LIM_W-1:0]   on_limit;
  logic               start_prev;
  logic               start_evt;
  logic               start_ok;

  // Falling edge of startn: a held button yields a single event.
  assign start_evt = start_prev & ~startn;

  // Out-of-range requests saturate at the top level.
  assign lvl_c = (power_level > LEVEL_MAX) ? LEVEL_MAX : power_level;

  // Common start/resume qualifiers (clear is handled by priority ordering).
  assign start_ok = start_evt & door_closed & stopn & ~timer_done & (lvl_c != '0);

  // Next-state, counter and applied-level decode with fixed priority:
  // clear > (stop or door open) > timer_done > start.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lvl_nxt   = level_active;
    case (state)
      S_IDLE: begin
        if (start_ok && clearn) begin
          state_nxt = S_COOKING;
          cnt_nxt   = '0;
          lvl_nxt   = lvl_c;
        end
      end
      S_COOKING: begin
        if (!clearn) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          lvl_nxt   = '0;
        end else if (!stopn || !door_closed) begin
          state_nxt = S_PAUSED;
        end else if (timer_done) begin
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          // Level changes take effect only at a period boundary.
          cnt_nxt = '0;
          lvl_nxt = lvl_c;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PAUSED: begin
        if (!clearn) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          lvl_nxt   = '0;
        end else if (start_ok) begin
          state_nxt = S_COOKING;
          cnt_nxt   = '0;
          lvl_nxt   = lvl_c;
        end
      end
      S_DONE: begin
        if (!clearn || !door_closed) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          lvl_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        lvl_nxt   = '0;
      end
    endcase
  end

  // State, period counter, applied level and start-button history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      level_active <= '0;
      start_prev   <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      level_active <= lvl_nxt;
      start_prev   <= startn;
    end
  end

  // On-time within the period; the door term is combinational so opening
  // the door kills the magnetron before the state machine reacts.
  assign on_limit = LIM_W'(level_active) * LIM_W'(SLOT_CYCLES);
  assign mag_on   = (state == S_COOKING) && ({1'b0, cnt} < on_limit) && door_closed;

  assign cooking = (state == S_COOKING);
  assign paused  = (state == S_PAUSED);
  assign done    = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_magnetron_power_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_magnetron_power_ctrl
//  Brief    : Directed self-checking bench for magnetron_power_ctrl.
//             Expected output vectors {mag_on,cooking,paused,done,level} are
//             queued when stimulus is applied and popped when sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_magnetron_power_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       timer_done;
  logic [3:0] power_level;
  logic       mag_on;
  logic       cooking;
  logic       paused;
  logic       done;
  logic [3:0] level_active;
  logic [7:0] obs;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];

  magnetron_power_ctrl #(
    .MAX_LEVEL  (10),
    .SLOT_CYCLES(4),
    .LEVEL_W    (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .power_level (power_level),
    .mag_on      (mag_on),
    .cooking     (cooking),
    .paused      (paused),
    .done        (done),
    .level_active(level_active)
  );

  always #5 clk = ~clk;

  assign obs = {mag_on, cooking, paused, done, level_active};

  function automatic logic [7:0] v_cook(input logic m, input logic [3:0] l);
    return {m, 1'b1, 1'b0, 1'b0, l};
  endfunction

  function automatic logic [7:0] v_pause(input logic [3:0] l);
    return {1'b0, 1'b0, 1'b1, 1'b0, l};
  endfunction

  function automatic logic [7:0] v_done(input logic [3:0] l);
    return {1'b0, 1'b0, 1'b0, 1'b1, l};
  endfunction

  localparam logic [7:0] V_IDLE = 8'h00;

  task automatic push_exp(input string tag, input logic [7:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic pop_cmp();
    exp_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard: observed %b with no expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.v) else begin
        tests_failed++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  // Sample #1 after the rising edge; stimulus is changed at the same point.
  task automatic step(input string tag, input logic [7:0] v);
    push_exp(tag, v);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  // Check a combinational/asynchronous response without a clock edge.
  task automatic now(input string tag, input logic [7:0] v);
    push_exp(tag, v);
    #1;
    pop_cmp();
  endtask

  initial begin
    logic [3:0] lv;
    resetn      = 1'b0;
    startn      = 1'b1;
    stopn       = 1'b1;
    clearn      = 1'b1;
    door_closed = 1'b1;
    timer_done  = 1'b0;
    power_level = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    now("reset", V_IDLE);
    resetn = 1'b1;
    step("idle_after_reset", V_IDLE);

    // 1: full power, continuous on across period wraps
    power_level = 4'd10;
    startn = 1'b0;
    step("t1_start", v_cook(1'b1, 4'd10));
    startn = 1'b1;
    for (int k = 1; k <= 85; k++) step($sformatf("t1_full k=%0d", k), v_cook(1'b1, 4'd10));
    clearn = 1'b0;
    step("t1_clear", V_IDLE);
    clearn = 1'b1;

    // 2: level 3 duty (12 on / 28 off), change to 5 at cnt=15 applies at wrap
    power_level = 4'd3;
    startn = 1'b0;
    step("t2_start", v_cook(1'b1, 4'd3));
    startn = 1'b1;
    for (int k = 1; k < 160; k++) begin
      lv = (k >= 120) ? 4'd5 : 4'd3;
      step($sformatf("t2_duty k=%0d", k), v_cook(((k % 40) < (int'(lv) * 4)), lv));
      if (k == 95) power_level = 4'd5;
    end
    clearn = 1'b0;
    step("t2_clear", V_IDLE);
    clearn = 1'b1;

    // 3: door interlock, pause, ignored timer, resume restarts the period
    power_level = 4'd10;
    startn = 1'b0;
    step("t3_start", v_cook(1'b1, 4'd10));
    startn = 1'b1;
    for (int k = 1; k <= 3; k++) step("t3_cook", v_cook(1'b1, 4'd10));
    door_closed = 1'b0;
    now("t3_door_comb", v_cook(1'b0, 4'd10));
    step("t3_paused", v_pause(4'd10));
    door_closed = 1'b1;
    for (int k = 0; k < 3; k++) step("t3_hold_paused", v_pause(4'd10));
    timer_done = 1'b1;
    step("t3_timer_ignored", v_pause(4'd10));
    timer_done = 1'b0;
    startn = 1'b0;
    step("t3_resume", v_cook(1'b1, 4'd10));
    startn = 1'b1;
    power_level = 4'd3;
    for (int k = 1; k <= 44; k++) begin
      if (k < 40) step($sformatf("t3_after k=%0d", k), v_cook(1'b1, 4'd10));
      else step($sformatf("t3_after k=%0d", k), v_cook(((k - 40) < 12), 4'd3));
    end
    clearn = 1'b0;
    step("t3_clear", V_IDLE);
    clearn = 1'b1;

    // 4: timer expiry, start ignored in DONE, clear returns to IDLE
    power_level = 4'd10;
    startn = 1'b0;
    step("t4_start", v_cook(1'b1, 4'd10));
    startn = 1'b1;
    step("t4_cook", v_cook(1'b1, 4'd10));
    timer_done = 1'b1;
    step("t4_done", v_done(4'd10));
    timer_done = 1'b0;
    startn = 1'b0;
    for (int k = 0; k < 10; k++) step("t4_start_in_done", v_done(4'd10));
    startn = 1'b1;
    clearn = 1'b0;
    step("t4_clear", V_IDLE);
    clearn = 1'b1;

    // 5a: clear beats stop
    startn = 1'b0;
    step("t5a_start", v_cook(1'b1, 4'd10));
    startn = 1'b1;
    stopn = 1'b0;
    clearn = 1'b0;
    step("t5a_clear_over_stop", V_IDLE);
    stopn = 1'b1;
    clearn = 1'b1;
    step("t5a_idle", V_IDLE);

    // 5b: level 0 refuses to start
    power_level = 4'd0;
    startn = 1'b0;
    step("t5b_level0", V_IDLE);
    startn = 1'b1;
    step("t5b_idle", V_IDLE);

    // 5c: out-of-range level clamps to the maximum
    power_level = 4'd15;
    startn = 1'b0;
    step("t5c_clamp", v_cook(1'b1, 4'd10));
    clearn = 1'b0;
    step("t5c_clear", V_IDLE);
    clearn = 1'b1;

    // 5d: startn still held low from above -> no second start
    for (int k = 0; k < 5; k++) step("t5d_held_no_restart", V_IDLE);
    startn = 1'b1;
    step("t5d_release", V_IDLE);

    // 6: asynchronous reset mid-cook, no restart without a new press
    power_level = 4'd10;
    startn = 1'b0;
    step("t6_start", v_cook(1'b1, 4'd10));
    startn = 1'b1;
    step("t6_cook", v_cook(1'b1, 4'd10));
    resetn = 1'b0;
    now("t6_async_reset", V_IDLE);
    step("t6_in_reset", V_IDLE);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) step("t6_no_restart", V_IDLE);
    startn = 1'b0;
    step("t6_new_start", v_cook(1'b1, 4'd10));
    startn = 1'b1;
    step("t6_cook_again", v_cook(1'b1, 4'd10));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
